// File: rtl/aq32_sram_arb_if.sv
// aq32_sram_arb_if: CPU word port, DMA byte port and external SRAM/ebus pins
// of the AQ32 SRAM arbiter grouped into one bundle.
// slave  : the arbiter itself.
// master : the surrounding fabric (requesters, SRAM pins, Z80 bus acknowledge).
interface aq32_sram_arb_if;
    // CPU word port
    logic [18:0] m0_addr;
    logic [31:0] m0_wrdata;
    logic [3:0]  m0_bytesel;
    logic        m0_wren;
    logic        m0_strobe;
    logic        m0_wait;
    logic [31:0] m0_rddata;
    // DMA byte port
    logic [18:0] m1_addr;
    logic [7:0]  m1_wrdata;
    logic        m1_wren;
    logic        m1_strobe;
    logic        m1_wait;
    logic [7:0]  m1_rddata;
    // SRAM / ebus side
    logic [18:0] sram_a;
    logic [7:0]  sram_wrdata;
    logic        sram_wrdata_oe;
    logic [7:0]  sram_rddata;
    logic        bus_en;
    logic        ram_ce_n;
    logic        rd_n;
    logic        ram_we_n;
    logic        busreq_n;
    logic        busack_n;

    modport slave (
        input  m0_addr, m0_wrdata, m0_bytesel, m0_wren, m0_strobe,
        output m0_wait, m0_rddata,
        input  m1_addr, m1_wrdata, m1_wren, m1_strobe,
        output m1_wait, m1_rddata,
        output sram_a, sram_wrdata, sram_wrdata_oe,
        input  sram_rddata,
        output bus_en, ram_ce_n, rd_n, ram_we_n, busreq_n,
        input  busack_n
    );

    modport master (
        output m0_addr, m0_wrdata, m0_bytesel, m0_wren, m0_strobe,
        input  m0_wait, m0_rddata,
        output m1_addr, m1_wrdata, m1_wren, m1_strobe,
        input  m1_wait, m1_rddata,
        input  sram_a, sram_wrdata, sram_wrdata_oe,
        output sram_rddata,
        input  bus_en, ram_ce_n, rd_n, ram_we_n, busreq_n,
        output busack_n
    );
endinterface

// File: rtl/aq32_sram_arb.sv
// aq32_sram_arb: shares the external 512 KB x8 asynchronous SRAM between the
// AQ32 CPU word port (m0) and the ESP32 DMA byte port (m1). CPU words are split
// into byte cycles SETUP -> STROBE (STROBE_CYCLES) -> RECOVER, then one DONE
// cycle completes the request. Ties are round-robin, m0 first after reset.
// Optional build macro EBUS_Z80_BUSREQ_EN: request the Z80 bus via busreq_n
// and wait in ACQ for the synchronized busack_n before touching the SRAM.
module aq32_sram_arb #(
    parameter int STROBE_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    aq32_sram_arb_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ACQ, S_SETUP, S_STROBE, S_RECOVER, S_DONE
    } state_t;

`ifdef EBUS_Z80_BUSREQ_EN
    localparam bit USE_ACQ = 1'b1;
`else
    localparam bit USE_ACQ = 1'b0;
`endif

    state_t      state_q;
    logic        owner_q;        // port being served: 0 = m0, 1 = m1
    logic        last_q;         // port served last; loses the next tie
    logic        wr_q;           // current transaction is a write
    logic [3:0]  rem_q;          // bytes still to be accessed
    logic [1:0]  idx_q;          // byte lane of the access in flight
    logic [3:0]  cnt_q;          // remaining STROBE cycles minus one
    logic [31:0] rdbuf_q;        // read bytes collected before completion
    logic [18:0] sram_a_q;
    logic [7:0]  sram_wrdata_q;
    logic        sram_oe_q;
    logic        ram_ce_n_q;
    logic        rd_n_q;
    logic        ram_we_n_q;
    logic        bus_en_q;
    logic        busreq_n_q;
    logic [31:0] m0_rddata_q;
    logic [7:0]  m1_rddata_q;

    logic        bus_held_d;
    logic        req_any_d;
    logic        grant_m1_d;
    logic        wren_d;
    logic [3:0]  mask_d;
    logic        src_owner_d;
    logic        src_wr_d;
    logic [3:0]  src_mask_d;
    logic [1:0]  nxt_idx_d;
    logic [18:0] nxt_addr_d;
    logic [7:0]  nxt_wdata_d;
    logic        launch_d;

    // Lowest pending byte lane; bytes are always accessed in ascending order.
    function automatic logic [1:0] first_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

`ifdef EBUS_Z80_BUSREQ_EN
    logic [1:0] ack_sync_q;

    // Two-flop synchronizer for the asynchronous Z80 bus acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ack_sync_q <= 2'b11;
        else       ack_sync_q <= {ack_sync_q[0], bus.busack_n};
    end
    assign bus_held_d = !ack_sync_q[1];
`else
    logic unused_busack;
    assign unused_busack = bus.busack_n;
    assign bus_held_d    = 1'b1;
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.m0_addr[1:0];

    // Arbitration: a single requester wins; on a tie the last-served port loses.
    assign req_any_d  = bus.m0_strobe || bus.m1_strobe;
    assign grant_m1_d = bus.m1_strobe && (!bus.m0_strobe || !last_q);
    assign wren_d     = grant_m1_d ? bus.m1_wren : bus.m0_wren;
    assign mask_d     = grant_m1_d ? 4'b0001 : (bus.m0_wren ? bus.m0_bytesel : 4'b1111);

    // Next byte to launch comes from the live request in IDLE, else from the
    // registered transaction; request fields are held stable while waiting.
    assign src_owner_d = (state_q == S_IDLE) ? grant_m1_d : owner_q;
    assign src_wr_d    = (state_q == S_IDLE) ? wren_d     : wr_q;
    assign src_mask_d  = (state_q == S_IDLE) ? mask_d     : rem_q;
    assign nxt_idx_d   = first_set(src_mask_d);
    assign nxt_addr_d  = src_owner_d ? bus.m1_addr : {bus.m0_addr[18:2], nxt_idx_d};
    assign nxt_wdata_d = src_owner_d ? bus.m1_wrdata : bus.m0_wrdata[{nxt_idx_d, 3'b000} +: 8];

    // Decide whether a byte cycle starts (enters SETUP) at the next edge.
    always_comb begin
        launch_d = 1'b0;
        case (state_q)
            S_IDLE:    launch_d = !USE_ACQ && req_any_d && (mask_d != 4'b0000);
            S_ACQ:     launch_d = bus_held_d;
            S_RECOVER: launch_d = (rem_q != 4'b0000);
            default:   launch_d = 1'b0;
        endcase
    end

    // Sequencer FSM with registered SRAM strobes, address and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            wr_q          <= 1'b0;
            rem_q         <= 4'b0000;
            idx_q         <= 2'd0;
            cnt_q         <= 4'd0;
            rdbuf_q       <= 32'h0;
            sram_a_q      <= 19'h0;
            sram_wrdata_q <= 8'h0;
            sram_oe_q     <= 1'b0;
            ram_ce_n_q    <= 1'b1;
            rd_n_q        <= 1'b1;
            ram_we_n_q    <= 1'b1;
            bus_en_q      <= 1'b0;
            busreq_n_q    <= 1'b1;
            m0_rddata_q   <= 32'h0;
            m1_rddata_q   <= 8'h0;
        end else begin
            if (!USE_ACQ) bus_en_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (req_any_d) begin
                        owner_q <= grant_m1_d;
                        last_q  <= grant_m1_d;
                        wr_q    <= wren_d;
                        rem_q   <= mask_d;
                        if (mask_d == 4'b0000) begin
                            state_q <= S_DONE;
                        end else if (USE_ACQ) begin
                            busreq_n_q <= 1'b0;
                            state_q    <= S_ACQ;
                        end
                    end else if (USE_ACQ) begin
                        busreq_n_q <= 1'b1;
                        bus_en_q   <= 1'b0;
                    end
                end
                S_ACQ: begin
                    // leave only through launch_d once the bus is held
                end
                S_SETUP: begin
                    cnt_q   <= 4'(STROBE_CYCLES - 1);
                    state_q <= S_STROBE;
                    if (wr_q) ram_we_n_q <= 1'b0;
                    else      rd_n_q     <= 1'b0;
                end
                S_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) rdbuf_q[{idx_q, 3'b000} +: 8] <= bus.sram_rddata;
                        rd_n_q     <= 1'b1;
                        ram_we_n_q <= 1'b1;
                        ram_ce_n_q <= 1'b1;
                        state_q    <= S_RECOVER;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RECOVER: begin
                    if (rem_q == 4'b0000) begin
                        sram_oe_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (!wr_q) begin
                            if (owner_q) m1_rddata_q <= rdbuf_q[7:0];
                            else         m0_rddata_q <= rdbuf_q;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (launch_d) begin
                sram_a_q   <= nxt_addr_d;
                if (src_wr_d) sram_wrdata_q <= nxt_wdata_d;
                sram_oe_q  <= src_wr_d;
                ram_ce_n_q <= 1'b0;
                idx_q      <= nxt_idx_d;
                rem_q      <= src_mask_d & ~(4'b0001 << nxt_idx_d);
                bus_en_q   <= 1'b1;
                state_q    <= S_SETUP;
            end
        end
    end

    assign bus.m0_wait        = bus.m0_strobe && !((state_q == S_DONE) && !owner_q);
    assign bus.m1_wait        = bus.m1_strobe && !((state_q == S_DONE) &&  owner_q);
    assign bus.m0_rddata      = m0_rddata_q;
    assign bus.m1_rddata      = m1_rddata_q;
    assign bus.sram_a         = sram_a_q;
    assign bus.sram_wrdata    = sram_wrdata_q;
    assign bus.sram_wrdata_oe = sram_oe_q;
    assign bus.ram_ce_n       = ram_ce_n_q;
    assign bus.rd_n           = rd_n_q;
    assign bus.ram_we_n       = ram_we_n_q;
    assign bus.bus_en         = bus_en_q;
    assign bus.busreq_n       = busreq_n_q;
endmodule

// File: tb/tb_aq32_sram_arb.sv
// tb_aq32_sram_arb: directed stimulus for aq32_sram_arb with a scoreboard.
// Stimulus pushes expected completions and expected SRAM byte cycles into
// queues; a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_aq32_sram_arb;
    localparam int SC = 2;
`ifdef EBUS_Z80_BUSREQ_EN
    localparam int A = 1;
    localparam logic IDLE_BUS_EN = 1'b0;
`else
    localparam int A = 0;
    localparam logic IDLE_BUS_EN = 1'b1;
`endif

    typedef struct { logic [31:0] data; int due; } exp_t;
    typedef struct { logic we; logic [18:0] a; logic [7:0] d; } sexp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ce_cnt = 0;
    int   ce_first = -1;
    logic [7:0] mem [0:524287];

    exp_t  q0[$];
    exp_t  q1[$];
    sexp_t qs[$];

    aq32_sram_arb_if bus();
    aq32_sram_arb #(.STROBE_CYCLES(SC)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.sram_rddata = (!bus.ram_ce_n && !bus.rd_n) ? mem[bus.sram_a] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic void exp0(input logic [31:0] d, input int due);
        exp_t e; e.data = d; e.due = due; q0.push_back(e);
    endfunction
    function automatic void exp1(input logic [31:0] d, input int due);
        exp_t e; e.data = d; e.due = due; q1.push_back(e);
    endfunction
    function automatic void exps(input logic we, input logic [18:0] a, input logic [7:0] d);
        sexp_t e; e.we = we; e.a = a; e.d = d; qs.push_back(e);
    endfunction

    // SRAM model: preload, then write on every sampled write-strobe cycle.
    initial begin
        for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
        mem[19'h00104] = 8'h11; mem[19'h00105] = 8'h22;
        mem[19'h00106] = 8'h33; mem[19'h00107] = 8'h44;
        mem[19'h7FFFC] = 8'h01; mem[19'h7FFFD] = 8'h02;
        mem[19'h7FFFE] = 8'h03; mem[19'h7FFFF] = 8'h04;
        mem[19'h00200] = 8'h5A; mem[19'h00300] = 8'hEE;
        forever begin
            @(negedge clk);
            if (!bus.ram_we_n && !bus.ram_ce_n && bus.sram_wrdata_oe)
                mem[bus.sram_a] = bus.sram_wrdata;
        end
    end

    // Monitor: completions and SRAM byte cycles against the scoreboard.
    logic  st, st_prev = 1'b0;
    int    run = 0;
    exp_t  e;
    sexp_t se;
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
            st_prev = 1'b0;
        end else begin
            if (bus.m0_strobe && !bus.m0_wait) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL m0 completion: got one at cycle %0d, required none", cyc);
                end else begin
                    e = q0.pop_front();
                    check("m0 rddata", bus.m0_rddata, e.data);
                    check("m0 completion cycle", cyc, e.due);
                end
            end
            if (bus.m1_strobe && !bus.m1_wait) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL m1 completion: got one at cycle %0d, required none", cyc);
                end else begin
                    e = q1.pop_front();
                    check("m1 rddata", {24'h0, bus.m1_rddata}, e.data);
                    check("m1 completion cycle", cyc, e.due);
                end
            end
            st = !bus.rd_n || !bus.ram_we_n;
            if (st && !st_prev) begin
                if (qs.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sram cycle: got one at %h, required none", bus.sram_a);
                end else begin
                    se = qs.pop_front();
                    check("sram addr", bus.sram_a, se.a);
                    check("sram write dir", !bus.ram_we_n, se.we);
                    check("sram data oe", bus.sram_wrdata_oe, se.we);
                    if (se.we) check("sram wrdata", bus.sram_wrdata, se.d);
                end
            end
            if (st) run++;
            else if (st_prev) begin
                check("strobe width", run, SC);
                run = 0;
            end
            st_prev = st;
            if (!bus.ram_ce_n) begin
                ce_cnt++;
                if (ce_first < 0) ce_first = cyc;
            end
        end
    end

    task automatic wait_m0(input int n);
        int got = 0;
        int budget = 400;
        while (got < n && budget > 0) begin
            @(negedge clk);
            if (bus.m0_strobe && !bus.m0_wait) got++;
            budget--;
        end
        if (got < n) begin
            tests++; fails++;
            $display("FAIL m0 timeout: got %0d completions, required %0d", got, n);
        end
        @(posedge clk); #1;
        bus.m0_strobe = 1'b0;
    endtask

    task automatic wait_m1(input int n);
        int got = 0;
        int budget = 400;
        while (got < n && budget > 0) begin
            @(negedge clk);
            if (bus.m1_strobe && !bus.m1_wait) got++;
            budget--;
        end
        if (got < n) begin
            tests++; fails++;
            $display("FAIL m1 timeout: got %0d completions, required %0d", got, n);
        end
        @(posedge clk); #1;
        bus.m1_strobe = 1'b0;
    endtask

    task automatic m0_req(input logic [18:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic we);
        bus.m0_addr = a; bus.m0_wrdata = d; bus.m0_bytesel = be;
        bus.m0_wren = we; bus.m0_strobe = 1'b1;
    endtask

    task automatic m1_req(input logic [18:0] a, input logic [7:0] d, input logic we);
        bus.m1_addr = a; bus.m1_wrdata = d; bus.m1_wren = we; bus.m1_strobe = 1'b1;
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    int t0, a_cyc, ce0;
    initial begin
        reset = 1'b1;
        bus.m0_addr = '0; bus.m0_wrdata = '0; bus.m0_bytesel = '0;
        bus.m0_wren = 1'b0; bus.m0_strobe = 1'b0;
        bus.m1_addr = '0; bus.m1_wrdata = '0; bus.m1_wren = 1'b0; bus.m1_strobe = 1'b0;
        bus.busack_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ram_ce_n", bus.ram_ce_n, 1'b1);
        check("reset rd_n", bus.rd_n, 1'b1);
        check("reset ram_we_n", bus.ram_we_n, 1'b1);
        check("reset busreq_n", bus.busreq_n, 1'b1);
        check("reset bus_en", bus.bus_en, 1'b0);
        check("reset wrdata_oe", bus.sram_wrdata_oe, 1'b0);
        check("reset sram_a", bus.sram_a, 19'h0);
        check("reset sram_wrdata", bus.sram_wrdata, 8'h0);
        check("reset m0_rddata", bus.m0_rddata, 32'h0);
        check("reset m1_rddata", bus.m1_rddata, 8'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle bus_en", bus.bus_en, IDLE_BUS_EN);

        // Both ports from reset: m0, m1, m0, m1 with both strobes held.
        @(posedge clk); #1; t0 = cyc;
        m0_req(19'h00104, 32'h0, 4'h0, 1'b0);
        m1_req(19'h00200, 8'h0, 1'b0);
        exp0(32'h44332211, t0 + 17 + A);
        exp1(32'h0000005A, t0 + 23 + 2*A);
        exp0(32'h44332211, t0 + 41 + 3*A);
        exp1(32'h0000005A, t0 + 47 + 4*A);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exps(1'b0, 19'h00104 + 19'(i), 8'h0);
            exps(1'b0, 19'h00200, 8'h0);
        end
        fork
            wait_m0(2);
            wait_m1(2);
        join

        // m1 byte write.
        @(posedge clk); #1; t0 = cyc;
        m1_req(19'h00201, 8'h77, 1'b1);
        exp1(32'h0000005A, t0 + 5 + A);
        exps(1'b1, 19'h00201, 8'h77);
        wait_m1(1);
        check("mem 00201", mem[19'h00201], 8'h77);

        // m0 write, bytesel 1010 at the top of memory.
        @(posedge clk); #1; t0 = cyc;
        m0_req(19'h7FFFC, 32'hAABBCCDD, 4'b1010, 1'b1);
        exp0(32'h44332211, t0 + 9 + A);
        exps(1'b1, 19'h7FFFD, 8'hCC);
        exps(1'b1, 19'h7FFFF, 8'hAA);
        wait_m0(1);
        check("mem 7FFFC", mem[19'h7FFFC], 8'h01);
        check("mem 7FFFD", mem[19'h7FFFD], 8'hCC);
        check("mem 7FFFE", mem[19'h7FFFE], 8'h03);
        check("mem 7FFFF", mem[19'h7FFFF], 8'hAA);

        // m0 write with no byte enables: completion after one cycle, no SRAM cycle.
        @(posedge clk); #1; t0 = cyc; ce0 = ce_cnt;
        m0_req(19'h00000, 32'h12345678, 4'b0000, 1'b1);
        exp0(32'h44332211, t0 + 1);
        wait_m0(1);
        check("bytesel 0000 ce cycles", ce_cnt - ce0, 0);

        // Read back the partially written word, then one byte through m1.
        @(posedge clk); #1; t0 = cyc;
        m0_req(19'h7FFFE, 32'h0, 4'h0, 1'b0);
        exp0(32'hAA03CC01, t0 + 17 + A);
        for (int i = 0; i < 4; i++) exps(1'b0, 19'h7FFFC + 19'(i), 8'h0);
        wait_m0(1);
        @(posedge clk); #1; t0 = cyc;
        m1_req(19'h7FFFF, 8'h0, 1'b0);
        exp1(32'h000000AA, t0 + 5 + A);
        exps(1'b0, 19'h7FFFF, 8'h0);
        wait_m1(1);

        // Reset pulsed during STROBE of an m0 write.
        @(posedge clk); #1; t0 = cyc;
        m0_req(19'h00300, 32'h000000BB, 4'b0001, 1'b1);
        while (cyc < t0 + 2 + A) begin @(posedge clk); #1; end
        check("pre-reset we_n low", bus.ram_we_n, 1'b0);
        reset = 1'b1;
        bus.m0_strobe = 1'b0;
        #1;
        check("async reset ram_we_n", bus.ram_we_n, 1'b1);
        check("async reset ram_ce_n", bus.ram_ce_n, 1'b1);
        check("async reset wrdata_oe", bus.sram_wrdata_oe, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ce0 = ce_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("post-reset ce cycles", ce_cnt - ce0, 0);
        check("post-reset m0_rddata", bus.m0_rddata, 32'h0);
        check("reset target byte intact", (mem[19'h00300] == 8'hEE) || (mem[19'h00300] == 8'hBB), 1'b1);
        @(posedge clk); #1; t0 = cyc;
        m1_req(19'h00104, 8'h0, 1'b0);
        exp1(32'h00000011, t0 + 5 + A);
        exps(1'b0, 19'h00104, 8'h0);
        wait_m1(1);

`ifdef EBUS_Z80_BUSREQ_EN
        // Slow Z80 bus acknowledge.
        repeat (4) @(posedge clk);
        #1;
        bus.busack_n = 1'b1;
        check("busreq released when idle", bus.busreq_n, 1'b1);
        check("bus_en released when idle", bus.bus_en, 1'b0);
        repeat (3) @(posedge clk);
        #1; t0 = cyc;
        m1_req(19'h00105, 8'h0, 1'b0);
        for (int b = 0; b < 20 && bus.busreq_n; b++) begin @(posedge clk); #1; end
        check("busreq asserted", bus.busreq_n, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        ce_first = -1;
        bus.busack_n = 1'b0;
        a_cyc = cyc;
        exp1(32'h00000022, a_cyc + 7);
        exps(1'b0, 19'h00105, 8'h0);
        wait_m1(1);
        check("ce after synchronized ack", ce_first >= a_cyc + 2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("busreq released after", bus.busreq_n, 1'b1);
        check("bus_en released after", bus.bus_en, 1'b0);
`endif

        repeat (3) @(posedge clk);
        check("leftover expectations", q0.size() + q1.size() + qs.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aq32_sram_arb.md
# aq32_sram_arb

Arbiter and sequencer for the external 512 KB 8-bit asynchronous SRAM (IS61C5128AS) on the Aquarius+ expansion bus. It shares the SRAM between the AQ32 CPU word port (32-bit, byte-enabled) and a byte-wide DMA port used by the ESP32 SPI/loader path. It splits every CPU word into sequenced byte cycles and drives CE/OE/WE with programmable strobe width. Sits inside aq32_top between the CPU/DMA fabric and the ebus pins.

## Interface
- STROBE_CYCLES, 2: cycles rd_n/ram_we_n held low per byte (legal 1..15).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- m0_addr  in  19  CPU byte address; bits [1:0] ignored.
- m0_wrdata  in  32  CPU write data, little-endian.
- m0_bytesel  in  4  CPU write byte enables.
- m0_wren  in  1  1 = write, 0 = read.
- m0_strobe  in  1  CPU request.
- m0_wait  out  1  stall; low on the completion cycle.
- m0_rddata  out  32  CPU read data.
- m1_addr  in  19  DMA byte address.
- m1_wrdata  in  8  DMA write data.
- m1_wren  in  1  1 = write.
- m1_strobe  in  1  DMA request.
- m1_wait  out  1  stall.
- m1_rddata  out  8  DMA read data.
- sram_a  out  19  to {ebus_ba, ebus_a[13:0]}.
- sram_wrdata  out  8  data to drive onto ebus_d.
- sram_wrdata_oe  out  1  ebus_d output enable.
- sram_rddata  in  8  ebus_d input.
- bus_en  out  1  enables ebus_a/rd_n/wr_n drivers.
- ram_ce_n, rd_n, ram_we_n  out  1 each  SRAM strobes.
- busreq_n  out  1  Z80 bus request.
- busack_n  in  1  Z80 bus acknowledge (asynchronous).

## Operation
- Handshake: mX_wait = mX_strobe && !done_X (combinational). Requester holds all request fields stable while wait=1. A completion cycle has wait=0, and rddata is valid in that cycle and held until the next completion. Strobe still high after completion is a new request.
- Arbitration happens only in IDLE. If one port requests, it wins. If both request, round-robin applies: the last-served port loses. After reset, m0 has priority.
- FSM: IDLE → [ACQ] → SETUP → STROBE → RECOVER → (next byte: SETUP | DONE) → IDLE.
  - SETUP (1 cycle): sram_a valid, ram_ce_n=0.
  - STROBE (STROBE_CYCLES cycles): rd_n=0 or ram_we_n=0. The read byte is latched on the last STROBE cycle.
  - RECOVER (1 cycle): strobes high, ce_n high.
  - DONE (1 cycle): completion cycle.
- m0 read accesses all 4 bytes at {addr[18:2],i} for i=0..3. Byte i maps to rddata[8i+7:8i].
- m0 write accesses only bytes with bytesel[i]=1, in ascending order. bytesel=0000 goes IDLE → DONE with no SRAM cycle.
- m1 performs one byte access at m1_addr.
- sram_wrdata_oe=1 from SETUP through RECOVER of write bytes only.
- sram_a holds its last value outside accesses.

## Timing
- Cycle 0 is the first IDLE cycle with strobe=1 and the port granted. Completion comes at cycle 1 + n·(STROBE_CYCLES+2), with n = bytes accessed. ACQ time is added when enabled.
- Examples at STROBE_CYCLES=2: m0 read completes at cycle 17; m1 access at cycle 5; m0 write with bytesel=0101 at cycle 9; bytesel=0000 at cycle 1.
- Back-to-back: a request pending in the DONE cycle is arbitrated in the next IDLE cycle (1 idle cycle between transactions).
- Reset values: ram_ce_n=1, rd_n=1, ram_we_n=1, busreq_n=1, bus_en=0, sram_wrdata_oe=0, sram_a=0, sram_wrdata=0, rddata=0, FSM=IDLE, priority=m0.
- Reset asserted mid-transaction: all strobes deassert asynchronously and the transaction is abandoned. The requester must re-issue after reset.
- Simultaneous new requests on both ports in the same cycle: the priority rule decides, and the loser keeps wait=1.

## Configuration
- EBUS_Z80_BUSREQ_EN defined:
  - busack_n passes through a 2-FF synchronizer.
  - In IDLE with a pending request, busreq_n goes low, and the FSM stays in ACQ until synchronized busack_n=0.
  - bus_en=1 from the first SETUP while the bus is held.
  - busreq_n/bus_en return to 1/0 in the first IDLE cycle with no pending request.
  - If busack_n deasserts mid-transaction, the current transaction still completes.
- Not defined:
  - There is no ACQ state, and busack_n is ignored.
  - busreq_n is constant 1.
  - bus_en=1 from the first cycle after reset is released.

## Test plan
- m0 read at 0x00104, SRAM preloaded with 11 22 33 44 → m0_rddata=0x44332211 at cycle 17; four SETUP/STROBE/RECOVER groups on sram_a 0x00104..0x00107.
- m0 write at 0x7FFFC, data 0xAABBCCDD, bytesel 1010 → only 0x7FFFD=CC and 0x7FFFF=AA written, completion at cycle 9, ram_we_n low exactly 2 cycles per byte.
- Both strobes high from reset → m0 served first, then m1; with both held, grants alternate m0, m1, m0.
- Reset pulsed during STROBE of an m0 write → ram_we_n/ram_ce_n high within the reset cycle, FSM in IDLE, target byte unchanged or fully written; no partial bus drive afterwards.
- EBUS_Z80_BUSREQ_EN, busack_n delayed 5 cycles after busreq_n → no ram_ce_n low before 2 synchronizer cycles after busack_n=0; busreq_n releases once idle.
- m0 write with bytesel=0000 → completion at cycle 1, ram_ce_n never asserted.
